alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 159 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit with valid/ready handshakes on input and output.
// Define ALU_FAST_SHIFT_EN to replace the bit-serial shifter with a barrel shifter.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      control_sig,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] CtlAdd  = 4'b0000;
  localparam logic [3:0] CtlSub  = 4'b1000;
  localparam logic [3:0] CtlSll  = 4'b0001;
  localparam logic [3:0] CtlSrl  = 4'b0101;
  localparam logic [3:0] CtlSra  = 4'b1101;
  localparam logic [3:0] CtlSlt  = 4'b0010;
  localparam logic [3:0] CtlSltu = 4'b0011;
  localparam logic [3:0] CtlXor  = 4'b0100;
  localparam logic [3:0] CtlOr   = 4'b0110;
  localparam logic [3:0] CtlAnd  = 4'b0111;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [XLEN-1:0] result_q;
  logic            illegal_q;
  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;
  logic [SHW-1:0]  shamt;
  logic            accept;

  assign shamt  = op_b[SHW-1:0];
  assign accept = (state_q == StIdle) && in_valid;

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] work_q, work_shift;
  logic [SHW-1:0]  count_q;
  logic [1:0]      shop_q;   // control_sig[3:2]: 00 SLL, 01 SRL, 11 SRA
  logic            is_shift;

  assign is_shift = (control_sig == CtlSll) || (control_sig == CtlSrl) ||
                    (control_sig == CtlSra);

  always_comb begin
    unique case (shop_q)
      2'b00:   work_shift = {work_q[XLEN-2:0], 1'b0};
      2'b01:   work_shift = {1'b0, work_q[XLEN-1:1]};
      default: work_shift = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end
`endif

  // One-cycle datapath; in the iterative build shifts only reach here with shamt == 0.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    unique case (control_sig)
      CtlAdd:  alu_res = op_a + op_b;
      CtlSub:  alu_res = op_a - op_b;
      CtlSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      CtlSltu: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      CtlXor:  alu_res = op_a ^ op_b;
      CtlOr:   alu_res = op_a | op_b;
      CtlAnd:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
      CtlSll:  alu_res = op_a << shamt;
      CtlSrl:  alu_res = op_a >> shamt;
      CtlSra:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
      CtlSll, CtlSrl, CtlSra: alu_res = op_a;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
          state_d = StDone;
`else
          state_d = (is_shift && (shamt != '0)) ? StShift : StDone;
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      StShift: if (count_q == SHW'(1)) state_d = StDone;
`endif
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    zero      = out_valid && (result_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      result_q  <= alu_res;
      illegal_q <= alu_illegal;
`ifndef ALU_FAST_SHIFT_EN
    end else if ((state_q == StShift) && (count_q == SHW'(1))) begin
      result_q  <= work_shift;
`endif
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q  <= '0;
      count_q <= '0;
      shop_q  <= 2'b00;
    end else if (accept) begin
      work_q  <= op_a;
      count_q <= shamt;
      shop_q  <= control_sig[3:2];
    end else if (state_q == StShift) begin
      work_q  <= work_shift;
      count_q <= count_q - SHW'(1);
    end
  end
`endif

  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; inputs driven and outputs sampled on negedge.
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit Iter = 1'b0;
`else
  localparam bit Iter = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  control_sig = 4'b0000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .control_sig(control_sig),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  // Present a request for one edge, then scramble inputs to show they are captured at accept.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    control_sig = c;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    control_sig = 4'b0000;
    op_a        = $urandom;
    op_b        = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    logic        ill;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v[13];
    int lat;
    v[0]  = '{4'b0000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1, 1'b0};
    v[1]  = '{4'b1000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1, 1'b0};
    v[2]  = '{4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 1'b0};
    v[3]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0};
    v[4]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0};
    v[5]  = '{4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1, 1'b0};
    v[6]  = '{4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1, 1'b0};
    v[7]  = '{4'b0001, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1, 1'b0};
    v[8]  = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, Iter ? 32 : 1, 1'b0};
    v[9]  = '{4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, Iter ? 32 : 1, 1'b0};
    v[10] = '{4'b1101, 32'h7000_0000, 32'h0000_0002, 32'h1C00_0000, Iter ? 3 : 1, 1'b0};
    v[11] = '{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 1'b1};
    v[12] = '{4'b1001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      send(v[i].c, v[i].a, v[i].b);
      wait_valid(lat);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
      total++; if (result !== v[i].res) begin bad++; $display("FAIL op%0d_result got=%h want=%h", i, result, v[i].res); end
      total++; if (zero !== (v[i].res == 32'h0)) begin bad++; $display("FAIL op%0d_zero got=%b want=%b", i, zero, v[i].res == 32'h0); end
      total++; if (illegal !== v[i].ill) begin bad++; $display("FAIL op%0d_illegal got=%b want=%b", i, illegal, v[i].ill); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL op%0d_in_ready_done got=%b want=0", i, in_ready); end
      drain();
    end
  endtask

  task automatic test_sra_iterative();
    int  cyc = 1;
    bit  busy_ok = 1'b1;
    send(4'b1101, 32'h8000_0000, 32'h0000_0004);
    while (!out_valid && cyc < 64) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc !== (Iter ? 5 : 1)) begin bad++; $display("FAIL sra_latency got=%0d want=%0d", cyc, Iter ? 5 : 1); end
    total++; if (busy_ok !== 1'b1) begin bad++; $display("FAIL sra_in_ready_busy got=%b want=1", busy_ok); end
    total++; if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra_result got=%h want=f8000000", result); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    send(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_valid(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL bp_latency got=%0d want=1", lat); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d got=%b want=1", i, out_valid); end
      total++; if (result !== 32'hF000_F000) begin bad++; $display("FAIL bp_hold_result%0d got=%h want=f000f000", i, result); end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_out_valid_after got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    send(4'b0110, 32'h0000_00A0, 32'h0000_000B);
    wait_valid(lat);
    total++; if (result !== 32'h0000_00AB) begin bad++; $display("FAIL rst_pre_result got=%h want=000000ab", result); end
    drain();
    send(4'b0001, 32'h0000_0001, 32'd20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", result); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(4'b0000, 32'h0000_0001, 32'h0000_0002);
    wait_valid(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL rst_post_latency got=%0d want=1", lat); end
    total++; if (result !== 32'h0000_0003) begin bad++; $display("FAIL rst_post_result got=%h want=3", result); end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_sra_iterative();
    test_backpressure();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
